// File: rtl/pwm_capture_if.sv
// pwm_capture_if
//   Bundles the PWM input and the measurement results of pwm_capture.
//   master : the measuring block (receives pwm_in, drives results)
//   slave  : the consumer (drives pwm_in, reads results)
//   pwm_in    - PWM waveform, asynchronous to slow_clk
//   period    - slow_clk cycles between consecutive rising edges
//   high_time - slow_clk cycles from a rising edge to the following falling edge
//   duty_pct  - floor(high_time*100/period), 0..100
//   valid     - one-cycle pulse when results update
//   timeout   - level, input stuck without edges
//   overrun   - sticky, a measurement was dropped while the divider was busy
interface pwm_capture_if #(
  parameter int unsigned CNT_W = 32
);
  logic             pwm_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [6:0]       duty_pct;
  logic             valid;
  logic             timeout;
  logic             overrun;

  modport master (
    input  pwm_in,
    output period, high_time, duty_pct, valid, timeout, overrun
  );

  modport slave (
    output pwm_in,
    input  period, high_time, duty_pct, valid, timeout, overrun
  );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures period and high time of an incoming PWM waveform in slow_clk
//   cycles and converts them into a duty cycle percentage with a sequential
//   restoring divider that runs alongside the next measurement.
//   slow_clk - clock, rising edge
//   rst      - asynchronous, active-high reset
//   bus      - pwm_capture_if master: pwm_in in; period, high_time,
//              duty_pct, valid, timeout, overrun out
module pwm_capture #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input logic           slow_clk,
  input logic           rst,
  pwm_capture_if.master bus
);
  localparam int unsigned NUM_W  = CNT_W + 7;
  localparam int unsigned IT_W   = $clog2(NUM_W);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;

  state_t state, state_nx;

  logic s0, s1, s2;
  logic rise, fall;

  logic [IDLE_W-1:0] idle_cnt;
  logic              to_fire;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  hi_cap;
  logic              hi_latch;
  logic              req;

  logic              busy;
  logic [IT_W-1:0]   iter;
  logic [CNT_W-1:0]  rem;
  logic [NUM_W-1:0]  nq;       // numerator shifts out the top, quotient shifts in the bottom
  logic [CNT_W-1:0]  den;
  logic [CNT_W-1:0]  dhi;
  logic [CNT_W:0]    rem_sh;
  logic              ge;
  logic [CNT_W-1:0]  rem_nx;
  logic [NUM_W-1:0]  nq_nx;
  logic [NUM_W-1:0]  num;
  logic              div_last;
  logic              accept;

  // Input synchronizer and edge detection
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s0 <= bus.pwm_in;
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;
  assign fall = ~s1 & s2;

  // Idle counter saturates at TIMEOUT, so the stuck event fires only once
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (rise || fall) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_W'(TIMEOUT)) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  assign to_fire = (idle_cnt == IDLE_W'(TIMEOUT - 1)) && !rise && !fall;

  // Measurement FSM
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) state <= WAIT_RISE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    hi_latch = 1'b0;
    req      = 1'b0;
    if (to_fire) begin
      state_nx = WAIT_RISE;
    end else begin
      case (state)
        WAIT_RISE: if (rise) state_nx = MEAS_HIGH;
        MEAS_HIGH: if (fall) begin
          hi_latch = 1'b1;
          state_nx = MEAS_LOW;
        end
        MEAS_LOW: if (rise) begin
          req      = 1'b1;
          state_nx = MEAS_HIGH;
        end
        default: state_nx = WAIT_RISE;
      endcase
    end
  end

  // cnt holds the number of cycles since the last rise, counting from 1
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      hi_cap <= '0;
    end else begin
      if (rise)
        cnt <= CNT_W'(1);
      else if (state != WAIT_RISE && cnt != '1)
        cnt <= cnt + CNT_W'(1);
      if (hi_latch)
        hi_cap <= cnt;
    end
  end

  // Restoring divider step
  always_comb begin
    rem_sh = {rem, nq[NUM_W-1]};
    ge     = (rem_sh >= {1'b0, den});
    rem_nx = ge ? CNT_W'(rem_sh - {1'b0, den}) : rem_sh[CNT_W-1:0];
    nq_nx  = {nq[NUM_W-2:0], ge};
  end

  assign num      = NUM_W'(hi_cap) * NUM_W'(100);
  assign div_last = busy && (iter == IT_W'(NUM_W - 1));
  // A request landing on the final iteration is accepted: the result is
  // registered from nq_nx while den/dhi are reloaded in the same edge.
  assign accept   = req && (!busy || div_last);

  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      iter <= '0;
      rem  <= '0;
      nq   <= '0;
      den  <= '0;
      dhi  <= '0;
    end else if (to_fire) begin
      busy <= 1'b0;
    end else if (accept) begin
      busy <= 1'b1;
      iter <= '0;
      rem  <= '0;
      nq   <= num;
      den  <= cnt;
      dhi  <= hi_cap;
    end else if (busy) begin
      iter <= iter + IT_W'(1);
      rem  <= rem_nx;
      nq   <= nq_nx;
      if (div_last) busy <= 1'b0;
    end
  end

  // Result registers; a stall report pre-empts a divide finishing in the same cycle
  always_ff @(posedge slow_clk or posedge rst) begin
    if (rst) begin
      bus.period    <= '0;
      bus.high_time <= '0;
      bus.duty_pct  <= '0;
      bus.valid     <= 1'b0;
      bus.timeout   <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      if (to_fire) begin
        bus.valid    <= 1'b1;
        bus.timeout  <= 1'b1;
        bus.duty_pct <= s2 ? 7'd100 : 7'd0;
      end else if (div_last) begin
        bus.valid     <= 1'b1;
        bus.timeout   <= 1'b0;
        bus.period    <= den;
        bus.high_time <= dhi;
        bus.duty_pct  <= nq_nx[6:0];
      end
      if (req && busy && !div_last)
        bus.overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 1000;
  localparam int          NUM_W   = CNT_W + 7;

  logic slow_clk = 1'b0;
  logic rst      = 1'b1;

  pwm_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .slow_clk (slow_clk),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 slow_clk = ~slow_clk;

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  bit finished = 1'b0;

  // Expected results, timestamped by the cycle in which valid must appear
  typedef struct {
    int due;
    bit is_to;
    int per;
    int hi;
    int duty;
  } res_t;

  res_t pend[$];

  // Event-level model state
  int last_edge = 0;
  int rise_t    = 0;
  int hi_len    = 0;
  int div_done  = 0;
  int phase     = 0;  // 0 waiting for rise, 1 high, 2 low
  bit pz1 = 1'b0, pz2 = 1'b0;  // pwm_in sampled one and two edges ago
  bit ovr_pending = 1'b0;

  int e_per = 0, e_hi = 0, e_duty = 0;
  bit e_valid = 1'b0, e_to = 1'b0, e_ovr = 1'b0;

  int last_valid_cyc  = 0;
  int last_rise_drive = 0;
  int to_valid_count  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge slow_clk) begin
    bit   rise_m, fall_m;
    int   per_m;
    res_t r;
    cyc++;
    if (rst) begin
      pend.delete();
      e_per = 0; e_hi = 0; e_duty = 0;
      e_valid = 1'b0; e_to = 1'b0; e_ovr = 1'b0;
      ovr_pending = 1'b0;
      div_done = 0;
      phase = 0;
      last_edge = cyc - 1;
      pz1 = 1'b0;
      pz2 = 1'b0;
    end else begin
      e_valid = 1'b0;
      if (ovr_pending) begin
        e_ovr = 1'b1;
        ovr_pending = 1'b0;
      end
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        e_valid = 1'b1;
        e_duty  = r.duty;
        if (r.is_to) begin
          e_to = 1'b1;
        end else begin
          e_to  = 1'b0;
          e_per = r.per;
          e_hi  = r.hi;
        end
      end
      rise_m = pz1 && !pz2;
      fall_m = !pz1 && pz2;
      if (rise_m || fall_m) begin
        last_edge = cyc;
      end else if (cyc == last_edge + int'(TIMEOUT)) begin
        pend.delete();
        pend.push_back('{cyc + 1, 1'b1, 0, 0, pz2 ? 100 : 0});
        div_done = 0;
        phase = 0;
      end
      case (phase)
        0: if (rise_m) begin
          phase = 1;
          rise_t = cyc;
        end
        1: if (fall_m) begin
          hi_len = cyc - rise_t;
          phase = 2;
        end
        default: if (rise_m) begin
          per_m = cyc - rise_t;
          if (cyc >= div_done) begin
            pend.push_back('{cyc + NUM_W + 1, 1'b0, per_m, hi_len, (hi_len * 100) / per_m});
            div_done = cyc + NUM_W;
          end else begin
            ovr_pending = 1'b1;
          end
          rise_t = cyc;
          phase = 1;
        end
      endcase
      pz2 = pz1;
      pz1 = bus.pwm_in;
    end
  end

  always @(negedge slow_clk) begin
    if (!finished) begin
      if (bus.valid) begin
        last_valid_cyc = cyc;
        if (bus.timeout) to_valid_count++;
      end
      if (rst) begin
        chk("rst_valid", bus.valid, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_period", bus.period, 0);
        chk("rst_high_time", bus.high_time, 0);
        chk("rst_duty", bus.duty_pct, 0);
      end else begin
        chk("valid", bus.valid, e_valid);
        chk("timeout", bus.timeout, e_to);
        chk("overrun", bus.overrun, e_ovr);
        chk("period", bus.period, e_per);
        chk("high_time", bus.high_time, e_hi);
        chk("duty", bus.duty_pct, e_duty);
      end
    end
  end

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge slow_clk);
      #1;
    end
  endtask

  task automatic pwm_cycles(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      bus.pwm_in = 1'b1;
      last_rise_drive = cyc;
      hold(hi);
      bus.pwm_in = 1'b0;
      hold(per - hi);
    end
  endtask

  task automatic lit_zero(input string tag);
    chk({tag, "_period"}, bus.period, 0);
    chk({tag, "_duty"}, bus.duty_pct, 0);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_overrun"}, bus.overrun, 0);
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    rst = 1'b1;
    hold(3);
    rst = 1'b0;
    lit_zero("reset");
    chk("reset_timeout", bus.timeout, 0);

    // Steady 100/25
    pwm_cycles(100, 25, 8);
    chk("lit_period_100", bus.period, 100);
    chk("lit_high_25", bus.high_time, 25);
    chk("lit_duty_25", bus.duty_pct, 25);
    chk("lit_rise_to_valid", last_valid_cyc - last_rise_drive, 26);

    // Floor behaviour
    pwm_cycles(200, 67, 4);
    chk("lit_duty_33", bus.duty_pct, 33);
    pwm_cycles(200, 199, 4);
    chk("lit_high_199", bus.high_time, 199);
    chk("lit_duty_99", bus.duty_pct, 99);

    // Mid-stream change of high time
    pwm_cycles(100, 25, 4);
    pwm_cycles(100, 75, 4);
    chk("lit_high_75", bus.high_time, 75);
    chk("lit_duty_75", bus.duty_pct, 75);

    // Stuck high, then stuck low, then recovery
    to_valid_count = 0;
    bus.pwm_in = 1'b1;
    hold(1500);
    chk("lit_stuck_hi_timeout", bus.timeout, 1);
    chk("lit_stuck_hi_duty", bus.duty_pct, 100);
    chk("lit_stuck_hi_period_held", bus.period, 100);
    chk("lit_stuck_hi_pulses", to_valid_count, 1);
    to_valid_count = 0;
    bus.pwm_in = 1'b0;
    hold(1500);
    chk("lit_stuck_lo_timeout", bus.timeout, 1);
    chk("lit_stuck_lo_duty", bus.duty_pct, 0);
    chk("lit_stuck_lo_pulses", to_valid_count, 1);
    pwm_cycles(100, 50, 4);
    chk("lit_recover_timeout", bus.timeout, 0);
    chk("lit_recover_duty", bus.duty_pct, 50);
    chk("lit_no_overrun_yet", bus.overrun, 0);

    // Too-short period
    pwm_cycles(10, 5, 30);
    chk("lit_overrun", bus.overrun, 1);
    chk("lit_overrun_duty", bus.duty_pct, 50);

    // Reset while in the low phase
    pwm_cycles(100, 50, 3);
    bus.pwm_in = 1'b1;
    hold(50);
    bus.pwm_in = 1'b0;
    hold(20);
    rst = 1'b1;
    #1;
    lit_zero("rst_low");
    hold(2);
    rst = 1'b0;
    pwm_cycles(100, 50, 3);
    chk("lit_after_rst_duty", bus.duty_pct, 50);

    // Reset while a divide is in flight
    bus.pwm_in = 1'b1;
    hold(10);
    rst = 1'b1;
    #1;
    lit_zero("rst_div");
    hold(2);
    rst = 1'b0;
    hold(40);

    // Randomized periods, including some too short for the divider
    for (int i = 0; i < 24; i++) begin
      int p, h, n;
      if ($urandom_range(0, 3) == 0) p = int'($urandom_range(4, 30));
      else                           p = int'($urandom_range(30, 300));
      h = int'($urandom_range(1, p - 1));
      n = int'($urandom_range(1, 4));
      pwm_cycles(p, h, n);
    end

    hold(40);
    finished = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
